// File: rtl/draw_port_arbiter_pkg.sv
// Shared drawing-path definitions: pixel bus widths, requester IDs and
// arbiter state encodings.
package draw_port_arbiter_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  localparam int unsigned REQ_BG   = 0;
  localparam int unsigned REQ_WALL = 1;
  localparam int unsigned REQ_BIRD = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

endpackage

// File: rtl/draw_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after 'pointer',
// wrapping modulo N_REQ. Returns a one-hot pick and a valid flag.
module draw_port_arbiter_rr_picker #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [2*N_REQ-1:0] req2;
  logic [2*N_REQ-1:0] pick2;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_pick;
  logic [PTR_W:0]     sh;

  // Rotate so candidate pointer+1 lands at bit 0, priority-scan, rotate back.
  always_comb begin
    sh       = {1'b0, pointer} + (PTR_W+1)'(1);
    req2     = {req, req};
    rot      = N_REQ'(req2 >> sh);
    rot_pick = '0;
    valid    = 1'b0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (!valid && rot[j]) begin
        rot_pick[j] = 1'b1;
        valid       = 1'b1;
      end
    end
    pick2 = {{N_REQ{1'b0}}, rot_pick} << sh;
    pick  = pick2[N_REQ-1:0] | pick2[2*N_REQ-1:N_REQ];
  end

endmodule

// File: rtl/draw_port_arbiter.sv
// Round-robin arbiter sharing the VGA pixel-write port between the
// background, wall and bird drawing engines, with frame-start priority to bg.
module draw_port_arbiter
  import draw_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned MAX_HOLD = 20000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          done,
  input  logic [N_REQ*X_W-1:0]      req_x,
  input  logic [N_REQ*Y_W-1:0]      req_y,
  input  logic [N_REQ*COLOUR_W-1:0] req_colour,
  input  logic [N_REQ-1:0]          req_plot,
  output logic [N_REQ-1:0]          gnt,
  output logic [X_W-1:0]            x_out,
  output logic [Y_W-1:0]            y_out,
  output logic [COLOUR_W-1:0]       colour_out,
  output logic                      plot_out,
  output logic                      busy,
  output logic                      timeout
);

  localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  g_idx;
  logic [PTR_W-1:0]  arb_ptr;
  logic [PTR_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick;
  logic              pick_valid;
  logic [HOLD_W-1:0] hold_cnt;
  logic              frame_pend;
  logic              done_g;
  logic              req_g;
  logic              hold_last;
  pixel_t            px_c;

  // RELEASE arbitrates with the just-released index so grants can run back to back.
  assign arb_ptr = (frame_pend || frame_start) ? PTR_W'(N_REQ-1)
                 : ((state == S_RELEASE) ? g_idx : ptr);

  draw_port_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req     (req),
    .pointer (arb_ptr),
    .pick    (pick),
    .valid   (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  assign done_g    = |(done & gnt);
  assign req_g     = |(req & gnt);
  assign hold_last = (hold_cnt == HOLD_W'(MAX_HOLD-1));

  // Pixel mux is zero whenever nothing is granted.
  always_comb begin
    px_c     = '0;
    plot_out = |(req_plot & gnt);
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) begin
        px_c.x      = px_c.x      | req_x[i*X_W +: X_W];
        px_c.y      = px_c.y      | req_y[i*Y_W +: Y_W];
        px_c.colour = px_c.colour | req_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign x_out      = px_c.x;
  assign y_out      = px_c.y;
  assign colour_out = px_c.colour;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      gnt        <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt   <= '0;
      ptr        <= PTR_W'(N_REQ-1);
      g_idx      <= '0;
      frame_pend <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (frame_start) frame_pend <= 1'b1;
      case (state)
        S_IDLE, S_RELEASE: begin
          hold_cnt <= '0;
          if (state == S_RELEASE) ptr <= g_idx;
          if (pick_valid) begin
            state      <= S_GRANT;
            gnt        <= pick;
            g_idx      <= pick_idx;
            busy       <= 1'b1;
            frame_pend <= 1'b0;
          end else begin
            state <= S_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        S_GRANT: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (done_g || !req_g || hold_last) begin
            state   <= S_RELEASE;
            gnt     <= '0;
            busy    <= 1'b1;
            timeout <= hold_last && req_g && !done_g;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Scoreboard bench for draw_port_arbiter: expected pixels and grant order are
// queued as stimulus is driven and matched when the DUT emits them.
module tb_draw_port_arbiter;
  import draw_port_arbiter_pkg::*;

  localparam int unsigned N = 3;

  typedef struct packed {
    logic [N-1:0]        g;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] c;
  } px_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  frame_start;
  logic [N-1:0]          req;
  logic [N-1:0]          done;
  logic [N*X_W-1:0]      req_x;
  logic [N*Y_W-1:0]      req_y;
  logic [N*COLOUR_W-1:0] req_colour;
  logic [N-1:0]          req_plot;
  logic [N-1:0]          gnt;
  logic [X_W-1:0]        x_out;
  logic [Y_W-1:0]        y_out;
  logic [COLOUR_W-1:0]   colour_out;
  logic                  plot_out;
  logic                  busy;
  logic                  timeout;

  int n_cmp = 0;
  int n_err = 0;

  px_t          px_q[$];
  logic [N-1:0] gnt_q[$];
  logic [N-1:0] prev_gnt = '0;

  draw_port_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .req        (req),
    .done       (done),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .req_plot   (req_plot),
    .gnt        (gnt),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot_out   (plot_out),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive nplots pixels from requester idx, done on the last; returns in RELEASE.
  task automatic serve(input int idx, input int nplots, input int bx, input int by, input int bc);
    for (int k = 0; k < nplots; k++) begin
      req_x[idx*X_W +: X_W]                = X_W'(bx + k);
      req_y[idx*Y_W +: Y_W]                = Y_W'(by + k);
      req_colour[idx*COLOUR_W +: COLOUR_W] = COLOUR_W'(bc);
      req_plot[idx] = 1'b1;
      done[idx]     = (k == nplots - 1);
      px_q.push_back({N'(1 << idx), X_W'(bx + k), Y_W'(by + k), COLOUR_W'(bc)});
      tick();
    end
    req_plot[idx] = 1'b0;
    done[idx]     = 1'b0;
  endtask

  // Output monitor: every plot must match the next queued pixel, every new grant the next queued grant.
  always @(negedge clk) begin
    if (!reset) begin
      if (plot_out) begin
        if (px_q.size() == 0) check("plot_unexpected", 32'(plot_out), 32'(0));
        else begin
          px_t e;
          e = px_q.pop_front();
          check("plot_px", 32'({gnt, x_out, y_out, colour_out}), 32'(e));
        end
      end
      if (gnt != '0 && prev_gnt == '0) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'(0));
        else check("gnt_order", 32'(gnt), 32'(gnt_q.pop_front()));
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #100000;
    check("watchdog", 32'(1), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0; req = '0; done = '0;
    req_x = '0; req_y = '0; req_colour = '0; req_plot = '0;

    // Reset then idle
    repeat (3) begin
      tick();
      check("rst_gnt", 32'(gnt), 32'(0));
      check("rst_out", 32'({plot_out, busy, timeout, x_out, y_out, colour_out}), 32'(0));
    end
    reset = 1'b0;
    tick();
    check("idle_gnt", 32'(gnt), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));

    // Single bird requester; a stray wall plot must be ignored
    req = 3'b100;
    gnt_q.push_back(3'b100);
    tick();
    check("single_gnt", 32'(gnt), 32'(3'b100));
    check("single_busy", 32'(busy), 32'(1));
    req_x[REQ_WALL*X_W +: X_W] = X_W'(99);
    req_plot[REQ_WALL] = 1'b1;
    serve(REQ_BIRD, 4, 40, 60, 6);
    req_plot[REQ_WALL] = 1'b0;
    req = 3'b000;
    check("single_rel_gnt", 32'(gnt), 32'(0));
    check("single_rel_plot", 32'(plot_out), 32'(0));
    check("single_rel_busy", 32'(busy), 32'(1));
    check("single_rel_x", 32'(x_out), 32'(0));
    tick();
    check("single_idle_busy", 32'(busy), 32'(0));

    // Round-robin 0,1,2,0 with one RELEASE cycle between grants
    req = 3'b111;
    gnt_q.push_back(3'b001); gnt_q.push_back(3'b010);
    gnt_q.push_back(3'b100); gnt_q.push_back(3'b001);
    tick();
    check("rr_gnt0", 32'(gnt), 32'(3'b001));
    serve(REQ_BG, 2, 10, 20, 1);
    check("rr_gap0", 32'({gnt, busy}), 32'({3'b000, 1'b1}));
    tick();
    check("rr_gnt1", 32'(gnt), 32'(3'b010));
    serve(REQ_WALL, 2, 30, 40, 2);
    check("rr_gap1", 32'({gnt, busy}), 32'({3'b000, 1'b1}));
    tick();
    check("rr_gnt2", 32'(gnt), 32'(3'b100));
    serve(REQ_BIRD, 2, 50, 70, 5);
    tick();
    check("rr_gnt3", 32'(gnt), 32'(3'b001));
    serve(REQ_BG, 2, 120, 100, 7);
    req = 3'b000;
    tick();
    check("rr_end_idle", 32'({gnt, busy}), 32'(0));

    // Frame start mid-grant: wall finishes, then bg beats bird
    req = 3'b010;
    gnt_q.push_back(3'b010);
    tick();
    req = 3'b111;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("fs_no_preempt", 32'(gnt), 32'(3'b010));
    serve(REQ_WALL, 2, 80, 90, 3);
    req = 3'b101;
    gnt_q.push_back(3'b001);
    tick();
    check("fs_bg_first", 32'(gnt), 32'(3'b001));
    serve(REQ_BG, 1, 1, 2, 4);
    req = 3'b000;
    tick();

    // Timeout: wall never finishes; bird is next
    req = 3'b010;
    gnt_q.push_back(3'b010);
    gnt_q.push_back(3'b100);
    tick();
    req = 3'b110;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("to_hold%0d", k), 32'({gnt, timeout}), 32'({3'b010, 1'b0}));
      tick();
    end
    check("to_rel_gnt", 32'(gnt), 32'(0));
    check("to_pulse", 32'(timeout), 32'(1));
    tick();
    check("to_pulse_end", 32'(timeout), 32'(0));
    check("to_next_gnt", 32'(gnt), 32'(3'b100));

    // Async reset while the bird is plotting
    req = 3'b100;
    req_x[REQ_BIRD*X_W +: X_W] = X_W'(7);
    req_y[REQ_BIRD*Y_W +: Y_W] = Y_W'(9);
    req_colour[REQ_BIRD*COLOUR_W +: COLOUR_W] = COLOUR_W'(2);
    req_plot[REQ_BIRD] = 1'b1;
    px_q.push_back({3'b100, X_W'(7), Y_W'(9), COLOUR_W'(2)});
    @(negedge clk);
    #2;
    check("arst_pre_plot", 32'(plot_out), 32'(1));
    reset = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'(0));
    check("arst_out", 32'({plot_out, busy, x_out, y_out, colour_out}), 32'(0));
    tick();
    req_plot = '0;
    req = 3'b101;
    gnt_q.push_back(3'b001);
    reset = 1'b0;
    tick();
    check("arst_bg_first", 32'(gnt), 32'(3'b001));
    serve(REQ_BG, 1, 3, 4, 5);
    req = 3'b000;
    tick();
    tick();

    check("px_q_drained", 32'(px_q.size()), 32'(0));
    check("gnt_q_drained", 32'(gnt_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
